// File: rtl/sys_rx_cmd_ctrl.sv
// rtl/sys_rx_cmd_ctrl.sv - UART RX command sequencer driving register file, ALU and TX FIFO
// Optional frame-abort timer enabled by defining FRAME_TIMEOUT_EN.
module sys_rx_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_Vld,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    FIFO_WR_INC,
  input  logic                    FIFO_FULL,
  output logic                    FRAME_ERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_ALU_OPA,
    S_ALU_OPB, S_ALU_FUN, S_ALU_WAIT, S_PUSH_LO, S_PUSH_HI
  } state_t;

  state_t                  r_state, w_state;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
  logic [2*DATA_WIDTH-1:0] r_result, w_result;
  logic                    r_rd_reply, w_rd_reply;
  logic [ADDR_WIDTH-1:0]   r_rf_addr, w_rf_addr;
  logic                    r_wr_en, w_wr_en, r_rd_en, w_rd_en;
  logic [DATA_WIDTH-1:0]   r_wr_data, w_wr_data;
  logic [FUN_WIDTH-1:0]    r_alu_fun, w_alu_fun;
  logic                    r_alu_en, w_alu_en, r_gate, w_gate;
  logic [DATA_WIDTH-1:0]   r_fifo_data, w_fifo_data;
  logic                    r_fifo_inc, w_fifo_inc, r_frame_err, w_frame_err;
  logic                    w_collect;
  logic                    w_timeout;

  assign w_collect = (r_state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
                                      S_ALU_OPA, S_ALU_OPB, S_ALU_FUN});

`ifdef FRAME_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counter restarts on every received byte and rests outside collect states.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                        r_tmo_cnt <= '0;
    else if (RX_D_VLD || !w_collect) r_tmo_cnt <= '0;
    else if (!w_timeout)             r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = w_collect && !RX_D_VLD && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_result    <= '0;
      r_rd_reply  <= 1'b0;
      r_rf_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_data   <= '0;
      r_alu_fun   <= '0;
      r_alu_en    <= 1'b0;
      r_gate      <= 1'b0;
      r_fifo_data <= '0;
      r_fifo_inc  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_addr      <= w_addr;
      r_result    <= w_result;
      r_rd_reply  <= w_rd_reply;
      r_rf_addr   <= w_rf_addr;
      r_wr_en     <= w_wr_en;
      r_rd_en     <= w_rd_en;
      r_wr_data   <= w_wr_data;
      r_alu_fun   <= w_alu_fun;
      r_alu_en    <= w_alu_en;
      r_gate      <= w_gate;
      r_fifo_data <= w_fifo_data;
      r_fifo_inc  <= w_fifo_inc;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_result    = r_result;
    w_rd_reply  = r_rd_reply;
    w_rf_addr   = r_rf_addr;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_wr_data   = r_wr_data;
    w_alu_fun   = r_alu_fun;
    w_alu_en    = r_alu_en;
    w_gate      = r_gate;
    w_fifo_data = r_fifo_data;
    w_fifo_inc  = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          DATA_WIDTH'(8'hAA): w_state = S_WR_ADDR;
          DATA_WIDTH'(8'hBB): w_state = S_RD_ADDR;
          DATA_WIDTH'(8'hCC): begin w_state = S_ALU_OPA; w_gate = 1'b1; end
          DATA_WIDTH'(8'hDD): w_state = S_ALU_FUN;
          default:            w_state = S_IDLE;
        endcase
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        w_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
        w_state = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        w_rf_addr = r_addr;
        w_wr_data = RX_P_DATA;
        w_wr_en   = 1'b1;
        w_state   = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        w_rf_addr = RX_P_DATA[ADDR_WIDTH-1:0];
        w_rd_en   = 1'b1;
        w_state   = S_RD_WAIT;
      end
      S_RD_WAIT: if (RF_RdData_Vld) begin
        w_result   = {{DATA_WIDTH{1'b0}}, RF_RdData};
        w_rd_reply = 1'b1;
        w_state    = S_PUSH_LO;
      end
      // Operands land in fixed RF slots 0/1 where the ALU reads them.
      S_ALU_OPA: if (RX_D_VLD) begin
        w_rf_addr = '0;
        w_wr_data = RX_P_DATA;
        w_wr_en   = 1'b1;
        w_state   = S_ALU_OPB;
      end
      S_ALU_OPB: if (RX_D_VLD) begin
        w_rf_addr = ADDR_WIDTH'(1);
        w_wr_data = RX_P_DATA;
        w_wr_en   = 1'b1;
        w_state   = S_ALU_FUN;
      end
      S_ALU_FUN: if (RX_D_VLD) begin
        w_alu_fun = RX_P_DATA[FUN_WIDTH-1:0];
        w_alu_en  = 1'b1;
        w_gate    = 1'b1;
        w_state   = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (ALU_OUT_VLD) begin
        w_result   = ALU_OUT;
        w_rd_reply = 1'b0;
        w_alu_en   = 1'b0;
        w_gate     = 1'b0;
        w_state    = S_PUSH_LO;
      end
      S_PUSH_LO: if (!FIFO_FULL) begin
        w_fifo_data = r_result[DATA_WIDTH-1:0];
        w_fifo_inc  = 1'b1;
        w_state     = r_rd_reply ? S_IDLE : S_PUSH_HI;
      end
      S_PUSH_HI: if (!FIFO_FULL) begin
        w_fifo_data = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
        w_fifo_inc  = 1'b1;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state     = S_IDLE;
      w_frame_err = 1'b1;
      w_gate      = 1'b0;
    end
  end

  assign RF_Address   = r_rf_addr;
  assign RF_WrEn      = r_wr_en;
  assign RF_RdEn      = r_rd_en;
  assign RF_WrData    = r_wr_data;
  assign ALU_FUN      = r_alu_fun;
  assign ALU_EN       = r_alu_en;
  assign CLK_GATE_EN  = r_gate;
  assign FIFO_WR_DATA = r_fifo_data;
  assign FIFO_WR_INC  = r_fifo_inc;
  assign FRAME_ERR    = r_frame_err;

endmodule

// File: tb/tb_sys_rx_cmd_ctrl.sv
// tb/tb_sys_rx_cmd_ctrl.sv - directed scoreboard bench for sys_rx_cmd_ctrl
module tb_sys_rx_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_Address;
  logic        RF_WrEn, RF_RdEn;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Vld;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, CLK_GATE_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic        FIFO_FULL;
  logic        FRAME_ERR;

  int n_chk = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, push_cnt = 0;
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [7:0]  exp_fifo[$];
  logic [7:0]  rf_mem[16];

  always #5 CLK = ~CLK;

  sys_rx_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_Vld(RF_RdData_Vld),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_INC(FIFO_WR_INC), .FIFO_FULL(FIFO_FULL), .FRAME_ERR(FRAME_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    rf_mem[a] = d;
  endtask

  task automatic wait_push(input int target);
    int n = 0;
    while (push_cnt < target && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("push_wait", push_cnt, target);
  endtask

  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return 16'(a & b);
    endcase
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      if (RF_WrEn) begin
        wr_cnt++;
        if (exp_wr.size() == 0) check("wr_unexpected", {RF_Address, RF_WrData}, 32'hFFFF_FFFF);
        else begin
          logic [11:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", RF_Address, e[11:8]);
          check("wr_data", RF_WrData, e[7:0]);
        end
      end
      if (RF_RdEn) begin
        rd_cnt++;
        if (exp_rd.size() == 0) check("rd_unexpected", RF_Address, 32'hFFFF_FFFF);
        else check("rd_addr", RF_Address, exp_rd.pop_front());
      end
      if (FIFO_WR_INC) begin
        push_cnt++;
        if (exp_fifo.size() == 0) check("push_unexpected", FIFO_WR_DATA, 32'hFFFF_FFFF);
        else check("push_data", FIFO_WR_DATA, exp_fifo.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] res;
    int p, n;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0; RF_RdData_Vld = 1'b0;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    repeat (3) @(negedge CLK);
    check("reset_strobes", {RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, FIFO_WR_INC, FRAME_ERR}, 0);
    check("reset_data", {RF_Address, RF_WrData, ALU_FUN, FIFO_WR_DATA}, 0);
    RST = 1'b1;
    @(negedge CLK);

    expect_wr(4'h5, 8'h3C);
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_latency", RF_WrEn, 1);
    repeat (3) @(negedge CLK);

    exp_rd.push_back(4'h5);
    exp_fifo.push_back(rf_mem[5]);
    p = push_cnt;
    send(8'hBB); send(8'h05);
    check("rd_latency", RF_RdEn, 1);
    @(negedge CLK);
    RF_RdData = rf_mem[5]; RF_RdData_Vld = 1'b1;
    @(negedge CLK);
    RF_RdData_Vld = 1'b0;
    wait_push(p + 1);

    send(8'hCC);
    check("gate_early", CLK_GATE_EN, 1);
    expect_wr(4'h0, 8'h07); send(8'h07);
    expect_wr(4'h1, 8'h03); send(8'h03);
    send(8'h00);
    check("alu_en_rise", ALU_EN, 1);
    check("alu_fun_cc", ALU_FUN, 0);
    repeat (3) @(negedge CLK);
    check("alu_en_held", {ALU_EN, CLK_GATE_EN}, 2'b11);
    res = alu_model(4'd0, rf_mem[0], rf_mem[1]);
    exp_fifo.push_back(res[7:0]); exp_fifo.push_back(res[15:8]);
    p = push_cnt;
    ALU_OUT = res; ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    check("alu_en_drop", {ALU_EN, CLK_GATE_EN}, 0);
    wait_push(p + 2);

    send(8'hDD); send(8'h02);
    check("alu_fun_dd", {ALU_EN, ALU_FUN}, 5'h12);
    res = alu_model(4'd2, rf_mem[0], rf_mem[1]);
    exp_fifo.push_back(res[7:0]); exp_fifo.push_back(res[15:8]);
    FIFO_FULL = 1'b1;
    p = push_cnt;
    ALU_OUT = res; ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    repeat (10) @(negedge CLK);
    check("full_no_push", push_cnt, p);
    FIFO_FULL = 1'b0;
    wait_push(p + 2);

    n = wr_cnt;
    send(8'h55);
    repeat (2) @(negedge CLK);
    check("ignored_opcode", {wr_cnt, ALU_EN, RF_RdEn}, {n, 2'b00});
    expect_wr(4'h1, 8'hFF);
    send(8'hAA); send(8'h01); send(8'hFF);
    repeat (2) @(negedge CLK);

    expect_wr(4'hB, 8'hCC);
    send(8'hAA); send(8'hBB); send(8'hCC);
    repeat (2) @(negedge CLK);

    send(8'hAA); send(8'h03);
    RST = 1'b0;
    #1;
    check("reset_mid_frame", {RF_WrEn, FIFO_WR_INC, ALU_EN}, 0);
    @(negedge CLK);
    RST = 1'b1;
    expect_wr(4'h4, 8'h77);
    send(8'hAA); send(8'h04); send(8'h77);
    repeat (2) @(negedge CLK);

`ifdef FRAME_TIMEOUT_EN
    send(8'hAA); send(8'h01);
    n = 0;
    while (!FRAME_ERR && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("tmo_cycles", n, 64);
    @(negedge CLK);
    check("tmo_pulse", FRAME_ERR, 0);
    expect_wr(4'h2, 8'h11);
    send(8'hAA); send(8'h02); send(8'h11);
    repeat (2) @(negedge CLK);
    check("wr_total", wr_cnt, 7);
`else
    check("wr_total", wr_cnt, 6);
    check("frame_err_off", FRAME_ERR, 0);
`endif

    repeat (5) @(negedge CLK);
    check("push_total", push_cnt, 5);
    check("rd_total", rd_cnt, 1);
    check("queues_empty", exp_wr.size() + exp_rd.size() + exp_fifo.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
